// File: rtl/mem_access_pkg.sv
// mem_access_pkg: access-size encodings, memory-stage FSM states and alignment check
package mem_access_pkg;
    localparam logic [2:0] MEM_B = 3'd0;
    localparam logic [2:0] MEM_H = 3'd1;
    localparam logic [2:0] MEM_W = 3'd2;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;
    function automatic logic align_fault(input logic [2:0] opt, input logic [1:0] addr);
        return (opt > MEM_W) || (opt == MEM_H && addr[0]) || (opt == MEM_W && addr != 2'b00);
    endfunction
endpackage

// File: rtl/mem_access_load_extract.sv
// load_extract: selects the addressed byte/half of a load word and sign- or zero-extends it
module load_extract
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      opt,
    input  logic            sgn,
    output logic [XLEN-1:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = rdata[{addr, 3'b000} +: 8];
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        result = opt == MEM_B ? {{(XLEN-8){sgn & b[7]}}, b}
               : opt == MEM_H ? {{(XLEN-16){sgn & h[15]}}, h} : rdata;
    end
endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage of the rv32 core; data-bus access, store steering, load extension.
// Define MEM_ACCESS_PERF_EN to add the stall_cycles counter output.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NSTRB = XLEN / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  aluresult,
    input  logic [XLEN-1:0]  rbdata,
    input  logic             mem_load,
    input  logic             mem_wr,
    input  logic [2:0]       mem_opt,
    input  logic             mem_signed,
    input  logic             reg_wr,
    input  logic [4:0]       reg_wnum,
    output logic             dbus_req_valid,
    input  logic             dbus_req_ready,
    output logic             dbus_we,
    output logic [XLEN-1:0]  dbus_addr,
    output logic [XLEN-1:0]  dbus_wdata,
    output logic [NSTRB-1:0] dbus_wstrb,
    input  logic             dbus_rsp_valid,
    input  logic [XLEN-1:0]  dbus_rdata,
    output logic             wb_valid,
    output logic             wb_reg_wr,
    output logic [4:0]       wb_reg_wnum,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_fault
`ifdef MEM_ACCESS_PERF_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);
    mem_state_t      state;
    logic [XLEN-1:0] addr_q;
    logic [2:0]      opt_q;
    logic            sgn_q;
    logic            reg_wr_q;
    logic [4:0]      wnum_q;
    logic            is_mem;
    logic            fault;
    logic [XLEN-1:0] st_wdata;
    logic [NSTRB-1:0] st_wstrb;
    logic [XLEN-1:0] ld_result;

    always_comb begin
        in_ready = rst_n && state == IDLE;
        is_mem   = mem_load || mem_wr;
        fault    = is_mem && ((mem_load && mem_wr) || align_fault(mem_opt, aluresult[1:0]));
        st_wdata = mem_opt == MEM_B ? {4{rbdata[7:0]}} : mem_opt == MEM_H ? {2{rbdata[15:0]}} : rbdata;
        st_wstrb = mem_opt == MEM_B ? 4'b0001 << aluresult[1:0]
                 : mem_opt == MEM_H ? 4'b0011 << aluresult[1:0] : 4'b1111;
        dbus_addr = {addr_q[XLEN-1:2], 2'b00};
    end

    load_extract #(.XLEN(XLEN)) u_load_extract (
        .rdata  (dbus_rdata),
        .addr   (addr_q[1:0]),
        .opt    (opt_q),
        .sgn    (sgn_q),
        .result (ld_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            addr_q         <= '0;
            opt_q          <= '0;
            sgn_q          <= 1'b0;
            reg_wr_q       <= 1'b0;
            wnum_q         <= '0;
            dbus_req_valid <= 1'b0;
            dbus_we        <= 1'b0;
            dbus_wdata     <= '0;
            dbus_wstrb     <= '0;
            wb_valid       <= 1'b0;
            wb_reg_wr      <= 1'b0;
            wb_reg_wnum    <= '0;
            wb_data        <= '0;
            wb_fault       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    if (!is_mem || fault) begin
                        wb_valid    <= 1'b1;
                        wb_data     <= aluresult;
                        wb_reg_wr   <= reg_wr && !fault;
                        wb_reg_wnum <= reg_wnum;
                        wb_fault    <= fault;
                    end else begin
                        state          <= REQ;
                        dbus_req_valid <= 1'b1;
                        dbus_we        <= mem_wr;
                        dbus_wdata     <= mem_wr ? st_wdata : '0;
                        dbus_wstrb     <= mem_wr ? st_wstrb : '0;
                        addr_q         <= aluresult;
                        opt_q          <= mem_opt;
                        sgn_q          <= mem_signed;
                        reg_wr_q       <= reg_wr;
                        wnum_q         <= reg_wnum;
                    end
                end
                REQ: if (dbus_req_ready) begin
                    dbus_req_valid <= 1'b0;
                    state          <= dbus_we ? IDLE : WAIT;
                    if (dbus_we) begin
                        wb_valid    <= 1'b1;
                        wb_reg_wr   <= 1'b0;
                        wb_reg_wnum <= wnum_q;
                        wb_data     <= addr_q;
                        wb_fault    <= 1'b0;
                    end
                end
                WAIT: if (dbus_rsp_valid) begin
                    state       <= IDLE;
                    wb_valid    <= 1'b1;
                    wb_reg_wr   <= reg_wr_q;
                    wb_reg_wnum <= wnum_q;
                    wb_data     <= ld_result;
                    wb_fault    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ACCESS_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cycles <= '0;
        else if (state != IDLE) stall_cycles <= stall_cycles + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed and randomized checks of mem_access against an arithmetic reference model
module tb_mem_access;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] aluresult = '0, rbdata = '0;
    logic        mem_load = 1'b0, mem_wr = 1'b0, mem_signed = 1'b0, reg_wr = 1'b0;
    logic [2:0]  mem_opt = '0;
    logic [4:0]  reg_wnum = '0;
    logic        dbus_req_valid, dbus_req_ready = 1'b0, dbus_we, dbus_rsp_valid = 1'b0;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata = '0;
    logic [3:0]  dbus_wstrb;
    logic        wb_valid, wb_reg_wr, wb_fault;
    logic [4:0]  wb_reg_wnum;
    logic [31:0] wb_data;
`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] s0;
`endif
    int passed = 0, total = 0;

    mem_access dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluresult(aluresult), .rbdata(rbdata), .mem_load(mem_load), .mem_wr(mem_wr),
        .mem_opt(mem_opt), .mem_signed(mem_signed), .reg_wr(reg_wr), .reg_wnum(reg_wnum),
        .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_rsp_valid(dbus_rsp_valid), .dbus_rdata(dbus_rdata),
        .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr), .wb_reg_wnum(wb_reg_wnum),
        .wb_data(wb_data), .wb_fault(wb_fault)
`ifdef MEM_ACCESS_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected values come from size/offset arithmetic, not from the DUT's steering logic.
    task automatic do_txn(input logic [31:0] a, input logic [31:0] rb, input logic ld, input logic st,
                          input logic [2:0] opt, input logic sg, input logic rw, input logic [4:0] wn,
                          input int rdy, input int rsp, input logic [31:0] rd);
        int sz, off;
        logic [31:0] mask, ew, es, ev;
        logic bad;
        sz   = opt == 3'd0 ? 1 : opt == 3'd1 ? 2 : 4;
        off  = int'(a[1:0]);
        bad  = (ld || st) && ((ld && st) || opt > 3'd2 || (off % sz) != 0);
        mask = sz == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
        ew   = (rb & mask) * (sz == 1 ? 32'h0101_0101 : sz == 2 ? 32'h0001_0001 : 32'd1);
        es   = ((32'd1 << sz) - 32'd1) << off;
        ev   = (rd >> (8 * off)) & mask;
        if (sg && sz < 4 && ev[8*sz-1]) ev = ev | ~mask;
        in_valid = 1'b1; aluresult = a; rbdata = rb; mem_load = ld; mem_wr = st;
        mem_opt = opt; mem_signed = sg; reg_wr = rw; reg_wnum = wn;
        chk("in_ready_idle", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        if (!(ld || st) || bad) begin
            chk("direct_wb_valid", 32'(wb_valid), 1);
            chk("direct_wb_data", wb_data, a);
            chk("direct_wb_reg_wr", 32'(wb_reg_wr), bad ? 0 : 32'(rw));
            chk("direct_wb_fault", 32'(wb_fault), 32'(bad));
            chk("direct_no_req", 32'(dbus_req_valid), 0);
            chk("direct_in_ready", 32'(in_ready), 1);
            if (!bad) chk("direct_wnum", 32'(wb_reg_wnum), 32'(wn));
        end else begin
            for (int i = 0; i <= rdy; i++) begin
                chk("req_valid", 32'(dbus_req_valid), 1);
                chk("req_in_ready", 32'(in_ready), 0);
                chk("req_addr", dbus_addr, {a[31:2], 2'b00});
                chk("req_we", 32'(dbus_we), 32'(st));
                chk("req_wdata", dbus_wdata, st ? ew : 32'd0);
                chk("req_wstrb", 32'(dbus_wstrb), st ? es : 32'd0);
                chk("req_no_wb", 32'(wb_valid), 0);
                dbus_rsp_valid = ld;
                dbus_rdata = ~rd;
                dbus_req_ready = (i == rdy);
                step();
            end
            dbus_req_ready = 1'b0;
            dbus_rsp_valid = 1'b0;
            if (st) begin
                chk("st_wb_valid", 32'(wb_valid), 1);
                chk("st_wb_reg_wr", 32'(wb_reg_wr), 0);
                chk("st_wb_fault", 32'(wb_fault), 0);
                chk("st_req_drop", 32'(dbus_req_valid), 0);
                chk("st_in_ready", 32'(in_ready), 1);
            end else begin
                chk("ld_no_early_wb", 32'(wb_valid), 0);
                chk("ld_req_drop", 32'(dbus_req_valid), 0);
                chk("ld_stall", 32'(in_ready), 0);
                for (int i = 0; i <= rsp; i++) begin
                    if (i == rsp) begin
                        dbus_rsp_valid = 1'b1;
                        dbus_rdata = rd;
                    end else chk("ld_wait_no_wb", 32'(wb_valid), 0);
                    step();
                end
                dbus_rsp_valid = 1'b0;
                chk("ld_wb_valid", 32'(wb_valid), 1);
                chk("ld_wb_data", wb_data, ev);
                chk("ld_wb_reg_wr", 32'(wb_reg_wr), 32'(rw));
                chk("ld_wb_wnum", 32'(wb_reg_wnum), 32'(wn));
                chk("ld_wb_fault", 32'(wb_fault), 0);
                chk("ld_in_ready", 32'(in_ready), 1);
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req_valid", 32'(dbus_req_valid), 0);
        chk("rst_we", 32'(dbus_we), 0);
        chk("rst_addr", dbus_addr, 0);
        chk("rst_wdata", dbus_wdata, 0);
        chk("rst_wstrb", 32'(dbus_wstrb), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_fault", 32'(wb_fault), 0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);

        do_txn(32'h1234, 32'h0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 5'd5, 0, 0, 32'h0);
        in_valid = 1'b1; aluresult = 32'h11; reg_wr = 1'b1; reg_wnum = 5'd1;
        mem_load = 1'b0; mem_wr = 1'b0;
        step();
        chk("b2b_first_valid", 32'(wb_valid), 1);
        chk("b2b_first_data", wb_data, 32'h11);
        chk("b2b_in_ready", 32'(in_ready), 1);
        aluresult = 32'h22; reg_wnum = 5'd2;
        step();
        chk("b2b_second_valid", 32'(wb_valid), 1);
        chk("b2b_second_data", wb_data, 32'h22);
        chk("b2b_second_wnum", 32'(wb_reg_wnum), 2);
        in_valid = 1'b0;
        step();
        chk("b2b_pulse_end", 32'(wb_valid), 0);

        do_txn(32'h103, 32'hAB, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 5'd3, 3, 0, 32'h0);
        do_txn(32'h202, 32'h0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 5'd7, 1, 2, 32'h8001_0000);
        chk("ld_h_signed_const", wb_data, 32'hFFFF_8001);
        do_txn(32'h202, 32'h0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b1, 5'd7, 0, 0, 32'h8001_0000);
        chk("ld_h_unsigned_const", wb_data, 32'h0000_8001);
        do_txn(32'h301, 32'h0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 5'd9, 0, 1, 32'h0000_FF00);
        chk("ld_b_signed_const", wb_data, 32'hFFFF_FFFF);

        do_txn(32'h6, 32'h0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 5'd4, 0, 0, 32'h0);
        do_txn(32'h8, 32'h0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 5'd4, 0, 0, 32'h0);
        do_txn(32'h10, 32'h5, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 5'd4, 0, 0, 32'h0);

        in_valid = 1'b1; aluresult = 32'h400; mem_load = 1'b0; mem_wr = 1'b1; mem_opt = 3'd2;
        step();
        in_valid = 1'b0;
        chk("rstreq_pre_valid", 32'(dbus_req_valid), 1);
        #2 rst_n = 1'b0;
        #1 chk("rstreq_async_drop", 32'(dbus_req_valid), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        in_valid = 1'b1; aluresult = 32'h500; mem_load = 1'b1; mem_wr = 1'b0; mem_opt = 3'd2;
        step();
        in_valid = 1'b0;
        dbus_req_ready = 1'b1;
        step();
        dbus_req_ready = 1'b0;
        chk("rstwait_stalled", 32'(in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstwait_req_valid", 32'(dbus_req_valid), 0);
        chk("rstwait_wb_valid", 32'(wb_valid), 0);
        chk("rstwait_wb_data", wb_data, 0);
        chk("rstwait_wb_reg_wr", 32'(wb_reg_wr), 0);
        chk("rstwait_wb_wnum", 32'(wb_reg_wnum), 0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rstwait_idle", 32'(in_ready), 1);
        @(negedge clk);
        dbus_rsp_valid = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
        step();
        dbus_rsp_valid = 1'b0;
        chk("stray_rsp_ignored", 32'(wb_valid), 0);
        chk("stray_rsp_idle", 32'(in_ready), 1);

        for (int n = 0; n < 60; n++) begin
            int op;
            logic [2:0] o;
            op = $urandom_range(0, 3);
            o  = $urandom_range(0, 9) < 8 ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            do_txn($urandom, $urandom, op == 1 || op == 3, op == 2 || op == 3, o, 1'($urandom),
                   1'($urandom), 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

`ifdef MEM_ACCESS_PERF_EN
        s0 = stall_cycles;
        do_txn(32'h700, 32'h0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b1, 5'd6, 2, 4, 32'hCAFE_F00D);
        chk("perf_nonidle_cycles", stall_cycles, s0 + 32'd8);
        step();
        chk("perf_idle_hold", stall_cycles, s0 + 32'd8);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-stage consumer of the EX/M pipeline register in the rv32 core.
- Takes the registered EX/M bundle and performs the data-memory access on a valid/ready data bus, with store byte-lane steering, load extraction and sign/zero extension.
- Presents a registered result to writeback and stalls upstream while a bus transaction is outstanding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NSTRB, XLEN/8, number of byte strobes.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX/M bundle valid
- in_ready  out  1  block can accept a bundle; drives the upstream stall
- aluresult  in  XLEN  effective address, or ALU result for non-memory ops
- rbdata  in  XLEN  store data (rs2)
- mem_load  in  1  load op
- mem_wr  in  1  store op
- mem_opt  in  3  access size: 0=byte, 1=half, 2=word, others illegal
- mem_signed  in  1  sign-extend loads
- reg_wr  in  1  writeback enable
- reg_wnum  in  5  destination register
- dbus_req_valid  out  1  bus request valid
- dbus_req_ready  in  1  bus request accepted
- dbus_we  out  1  1=store
- dbus_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- dbus_wdata  out  XLEN  lane-replicated store data
- dbus_wstrb  out  NSTRB  byte strobes
- dbus_rsp_valid  in  1  load data valid
- dbus_rdata  in  XLEN  load data (full word)
- wb_valid  out  1  one-cycle result pulse
- wb_reg_wr  out  1  writeback enable
- wb_reg_wnum  out  5  destination register
- wb_data  out  XLEN  load result or passthrough aluresult
- wb_fault  out  1  misaligned or illegal access

Behaviour:
- Reset values: all outputs 0, except in_ready=1 once rst_n is high; FSM in IDLE.
- Asserting rst_n low at any point (including mid-transaction) aborts immediately. dbus_req_valid drops asynchronously. A dbus_rsp_valid arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT.
- in_ready = (state==IDLE). A bundle is accepted on in_valid && in_ready.
- Non-memory op accepted (mem_load=0, mem_wr=0):
  - Stay in IDLE.
  - Next cycle: wb_valid=1, wb_data=aluresult, wb_reg_wr=reg_wr, wb_reg_wnum=reg_wnum.
  - Throughput 1 per cycle.
- mem_load and mem_wr both set: illegal; treated as a fault.
- Fault check, done at accept:
  - half with addr[0]=1, word with addr[1:0]!=0, or mem_opt>2 is a fault.
  - No bus request is issued.
  - Next cycle: wb_valid=1, wb_fault=1, wb_reg_wr=0, wb_data=aluresult.
- Legal memory op accepted:
  - Latch address, size, signedness and destination; go to REQ.
  - dbus_req_valid=1 registered from REQ entry. Address, we, wdata and wstrb are held stable until the handshake.
- Store lane steering:
  - byte: wdata={4{rb[7:0]}}, wstrb=0001<<addr[1:0].
  - half: wdata={2{rb[15:0]}}, wstrb=0011<<addr[1:0].
  - word: wdata=rb, wstrb=1111.
- Loads drive wstrb=0 and wdata=0.
- REQ + dbus_req_ready:
  - Store: go to IDLE; next cycle wb_valid=1, wb_reg_wr=0.
  - Load: go to WAIT.
- WAIT + dbus_rsp_valid:
  - Extract byte/half at addr[1:0] and sign- or zero-extend per mem_signed.
  - Next cycle: wb_valid=1, wb_data=result, wb_reg_wr=latched reg_wr; return to IDLE.
- dbus_rsp_valid in IDLE or REQ is ignored.
- A response in the same cycle as the request handshake is not accepted; the bus guarantees at least 1 cycle of latency.
- Minimum latency: store 2 cycles, load 3 cycles from accept to wb_valid.
- Writes to reg_wnum=0 pass through unchanged; the regfile discards them.

Optional Feature:
- Macro MEM_ACCESS_PERF_EN.
- Defined: adds output stall_cycles (32 bit), reset 0. It increments every cycle state!=IDLE and wraps at 2^32-1 to 0.
- Undefined: the port and counter are absent; there is no other behavioural difference.

Decomposition:
- Shared package (alongside common/decode definitions):
  - mem_opt encodings MEM_B/MEM_H/MEM_W.
  - FSM state enum mem_state_t.
  - function align_fault(opt, addr).
- Sub-module load_extract: combinational, inputs rdata, addr[1:0], opt, signed; output XLEN result. Shared later with the writeback-side forwarding.

Test Plan:
- Non-memory op, aluresult=0x1234, reg_wr=1, reg_wnum=5 -> next cycle wb_valid=1, wb_data=0x1234, in_ready stays 1; back-to-back bundles give wb_valid on consecutive cycles.
- Store byte, addr=0x103, rbdata=0xAB, dbus_req_ready delayed 3 cycles -> dbus_addr=0x100, wstrb=1000, wdata=0xABABABAB, signals stable while stalled, in_ready=0 until handshake, then wb_valid with wb_reg_wr=0.
- Load half signed, addr=0x202, rdata=0x8001_0000 -> wb_data=0xFFFF8001; unsigned -> 0x00008001; load byte signed at addr[1:0]=1, rdata=0x0000_FF00 -> 0xFFFFFFFF.
- Misaligned word load, addr=0x6 -> no dbus_req_valid, next cycle wb_valid=1, wb_fault=1, wb_reg_wr=0; mem_opt=3 gives the same response.
- rst_n low while in WAIT -> req_valid=0, state IDLE, all wb outputs 0; a subsequent stray rsp_valid produces no wb_valid.
- With MEM_ACCESS_PERF_EN: a load with a 2-cycle ready delay and 4-cycle response delay -> stall_cycles advances by exactly the number of non-IDLE cycles; a preset near 2^32-1 wraps to 0.
